// File: rtl/mcdf_arbiter.sv
// MCDF arbiter: grants one of three channels a fixed-length burst and streams
// its beats to the formatter. MCDF_ARB_RR_EN selects round-robin tie-break.
module mcdf_arbiter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] ch0_data_i,
    input  logic        ch0_valid_i,
    output logic        ch0_ready_o,
    input  logic        ch0_en_i,
    input  logic [1:0]  ch0_prio_i,
    input  logic [1:0]  ch0_len_i,
    input  logic [31:0] ch1_data_i,
    input  logic        ch1_valid_i,
    output logic        ch1_ready_o,
    input  logic        ch1_en_i,
    input  logic [1:0]  ch1_prio_i,
    input  logic [1:0]  ch1_len_i,
    input  logic [31:0] ch2_data_i,
    input  logic        ch2_valid_i,
    output logic        ch2_ready_o,
    input  logic        ch2_en_i,
    input  logic [1:0]  ch2_prio_i,
    input  logic [1:0]  ch2_len_i,
    output logic [31:0] a_data_o,
    output logic        a_valid_o,
    input  logic        a_ready_i,
    output logic [1:0]  a_id_o,
    output logic        a_sop_o,
    output logic        a_eop_o,
    output logic        busy_o
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]  state;
    logic [1:0]  grant_id;
    logic [5:0]  beat_cnt;
    logic        first_beat;

    logic [2:0]  elig;
    logic [2:0]  cand;
    logic [1:0]  ch_prio [3];
    logic [1:0]  min_prio;
    logic [1:0]  win_id;
    logic [1:0]  win_len;
    logic        sel_valid;
    logic [31:0] sel_data;
    logic        out_free;
    logic        xfer;
    logic        last_beat;

    function automatic logic [5:0] len_beats(input logic [1:0] code);
        case (code)
            2'd0:    len_beats = 6'd4;
            2'd1:    len_beats = 6'd8;
            2'd2:    len_beats = 6'd16;
            default: len_beats = 6'd32;
        endcase
    endfunction

    assign elig       = {ch2_en_i & ch2_valid_i, ch1_en_i & ch1_valid_i, ch0_en_i & ch0_valid_i};
    assign ch_prio[0] = ch0_prio_i;
    assign ch_prio[1] = ch1_prio_i;
    assign ch_prio[2] = ch2_prio_i;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        min_prio = 2'd3;
        for (int i = 0; i < 3; i++) begin
            if (elig[i] && (ch_prio[i] < min_prio)) min_prio = ch_prio[i];
        end
        for (int i = 0; i < 3; i++) cand[i] = elig[i] && (ch_prio[i] == min_prio);
    end

`ifdef MCDF_ARB_RR_EN
    logic [1:0] rr_ptr;
    int         rr_idx;
    logic       rr_found;

    // Search starts one past the last granted channel.
    always_comb begin
        win_id   = 2'd0;
        rr_found = 1'b0;
        rr_idx   = 0;
        for (int k = 0; k < 3; k++) begin
            rr_idx = (int'(rr_ptr) + k + 1) % 3;
            if (!rr_found && cand[rr_idx]) begin
                win_id   = 2'(rr_idx);
                rr_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr <= 2'd2;
        end else if ((state == ST_IDLE) && (|elig)) begin
            rr_ptr <= win_id;
        end
    end
`else
    always_comb begin
        if (cand[0])      win_id = 2'd0;
        else if (cand[1]) win_id = 2'd1;
        else              win_id = 2'd2;
    end
`endif

    always_comb begin
        case (win_id)
            2'd0:    win_len = ch0_len_i;
            2'd1:    win_len = ch1_len_i;
            default: win_len = ch2_len_i;
        endcase
        case (grant_id)
            2'd0:    begin sel_valid = ch0_valid_i; sel_data = ch0_data_i; end
            2'd1:    begin sel_valid = ch1_valid_i; sel_data = ch1_data_i; end
            default: begin sel_valid = ch2_valid_i; sel_data = ch2_data_i; end
        endcase
    end

    assign out_free    = !a_valid_o || a_ready_i;
    assign xfer        = (state == ST_BURST) && sel_valid && out_free && !rst_i;
    assign last_beat   = (beat_cnt == 6'd1);
    assign busy_o      = (state == ST_BURST);
    assign ch0_ready_o = (state == ST_BURST) && (grant_id == 2'd0) && out_free && !rst_i;
    assign ch1_ready_o = (state == ST_BURST) && (grant_id == 2'd1) && out_free && !rst_i;
    assign ch2_ready_o = (state == ST_BURST) && (grant_id == 2'd2) && out_free && !rst_i;

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            grant_id   <= 2'd0;
            beat_cnt   <= 6'd0;
            first_beat <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|elig) begin
                        grant_id   <= win_id;
                        beat_cnt   <= len_beats(win_len);
                        first_beat <= 1'b1;
                        state      <= ST_BURST;
                    end
                end
                default: begin
                    if (xfer) begin
                        beat_cnt   <= beat_cnt - 6'd1;
                        first_beat <= 1'b0;
                        if (last_beat) state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Output register: loads on a transfer, holds under backpressure.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_data_o  <= 32'd0;
            a_id_o    <= 2'd0;
            a_sop_o   <= 1'b0;
            a_eop_o   <= 1'b0;
            a_valid_o <= 1'b0;
        end else if (xfer) begin
            a_data_o  <= sel_data;
            a_id_o    <= grant_id;
            a_sop_o   <= first_beat;
            a_eop_o   <= last_beat;
            a_valid_o <= 1'b1;
        end else if (a_ready_i) begin
            a_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mcdf_arbiter.sv
// Scoreboard bench for mcdf_arbiter: burst-level reference model predicts the
// beat stream; a monitor compares every accepted beat. Honours MCDF_ARB_RR_EN.
module tb_mcdf_arbiter;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  id;
        logic        sop;
        logic        eop;
    } beat_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] ch_data  [3];
    logic        ch_valid [3];
    logic        ch_en    [3];
    logic [1:0]  ch_prio  [3];
    logic [1:0]  ch_len   [3];
    logic        ch0_ready, ch1_ready, ch2_ready;
    logic [2:0]  ch_ready;
    logic [31:0] a_data_o;
    logic        a_valid_o;
    logic        a_ready_i = 1'b0;
    logic [1:0]  a_id_o;
    logic        a_sop_o, a_eop_o, busy_o;

    always #5 clk_i = ~clk_i;
    assign ch_ready = {ch2_ready, ch1_ready, ch0_ready};

    mcdf_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ch0_data_i(ch_data[0]), .ch0_valid_i(ch_valid[0]), .ch0_ready_o(ch0_ready),
        .ch0_en_i(ch_en[0]), .ch0_prio_i(ch_prio[0]), .ch0_len_i(ch_len[0]),
        .ch1_data_i(ch_data[1]), .ch1_valid_i(ch_valid[1]), .ch1_ready_o(ch1_ready),
        .ch1_en_i(ch_en[1]), .ch1_prio_i(ch_prio[1]), .ch1_len_i(ch_len[1]),
        .ch2_data_i(ch_data[2]), .ch2_valid_i(ch_valid[2]), .ch2_ready_o(ch2_ready),
        .ch2_en_i(ch_en[2]), .ch2_prio_i(ch_prio[2]), .ch2_len_i(ch_len[2]),
        .a_data_o(a_data_o), .a_valid_o(a_valid_o), .a_ready_i(a_ready_i),
        .a_id_o(a_id_o), .a_sop_o(a_sop_o), .a_eop_o(a_eop_o), .busy_o(busy_o)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    beat_t       exp_q [$];
    logic [31:0] src_q [3][$];
    int          beats_sent [3];
    int          blen [3];
    int          gap_cnt [3];
    int          ready_pct = 100;
    int          bp_hold = 0;
    int          beats_out = 0;
    int          rr_last = 2;
    bit          gap_en = 1'b0;
    bit          hook_en = 1'b0;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Channel sources and formatter ready; inputs change 1 time unit after the edge.
    initial begin
        bit xf [3];
        for (int i = 0; i < 3; i++) begin
            ch_valid[i] = 1'b0; ch_data[i] = '0; ch_en[i] = 1'b0;
            ch_prio[i] = '0; ch_len[i] = '0; beats_sent[i] = 0; blen[i] = 4; gap_cnt[i] = 0;
        end
        forever begin
            @(negedge clk_i);
            for (int i = 0; i < 3; i++) xf[i] = ch_valid[i] && ch_ready[i];
            @(posedge clk_i);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (xf[i]) begin
                    if (src_q[i].size() > 0) void'(src_q[i].pop_front());
                    beats_sent[i]++;
                    if (hook_en && i == 2 && beats_sent[2] == 3) begin
                        gap_cnt[2] = 4; ch_en[2] = 1'b0; ch_prio[2] = 2'd3; ch_len[2] = 2'd0;
                    end else if (gap_en && (beats_sent[i] % blen[i]) != 0 && $urandom_range(3) == 0) begin
                        gap_cnt[i] = $urandom_range(3, 1);
                    end
                end
                if (gap_cnt[i] > 0) begin
                    gap_cnt[i]--;
                    ch_valid[i] = 1'b0;
                    ch_data[i]  = $urandom;
                end else begin
                    ch_valid[i] = (src_q[i].size() > 0);
                    ch_data[i]  = (src_q[i].size() > 0) ? src_q[i][0] : $urandom;
                end
            end
            if (bp_hold > 0) begin
                a_ready_i = 1'b0;
                bp_hold--;
            end else begin
                a_ready_i = ($urandom_range(99) < ready_pct);
            end
        end
    end

    // Monitor: compares accepted beats and the hold/ready rules every cycle.
    initial begin
        bit          prev_hold = 1'b0;
        logic [31:0] prev_data;
        logic [1:0]  prev_id;
        logic        prev_sop, prev_eop;
        beat_t       e;
        forever begin
            @(negedge clk_i);
            if (mon_en) begin
                if (prev_hold) begin
                    check("hold_valid", a_valid_o, 1'b1);
                    check("hold_data", a_data_o, prev_data);
                    check("hold_id", a_id_o, prev_id);
                    check("hold_sop_eop", {a_sop_o, a_eop_o}, {prev_sop, prev_eop});
                end
                if (a_valid_o && !a_ready_i) check("bp_ready", ch_ready, 3'b000);
                check("ready_onehot", $onehot0(ch_ready), 1'b1);
                if (!busy_o) check("idle_ready", ch_ready, 3'b000);
                if (a_valid_o && !prev_hold && a_eop_o) check("eop_gap_busy", busy_o, 1'b0);
                if (a_valid_o && a_ready_i) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_beat: got id %0d data %h, expected no beat", a_id_o, a_data_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", a_data_o, e.data);
                        check("beat_id", a_id_o, e.id);
                        check("beat_sop", a_sop_o, e.sop);
                        check("beat_eop", a_eop_o, e.eop);
                    end
                    beats_out++;
                end
            end
            prev_hold = a_valid_o && !a_ready_i;
            prev_data = a_data_o; prev_id = a_id_o; prev_sop = a_sop_o; prev_eop = a_eop_o;
        end
    end

    // Burst-level reference: pick winners by priority/tie rule, emit whole bursts.
    task automatic run_scenario(input logic [2:0] en, input logic [1:0] p0, p1, p2,
                                input logic [1:0] l0, l1, l2, input int n0, n1, n2);
        logic [1:0]  pr [3];
        logic [1:0]  ln [3];
        int          rem [3];
        int          pos [3];
        int          len [3];
        logic [31:0] gen [3][$];
        int          best, ch, cyc;
        beat_t       b;
        pr[0] = p0; pr[1] = p1; pr[2] = p2;
        ln[0] = l0; ln[1] = l1; ln[2] = l2;
        rem[0] = n0; rem[1] = n1; rem[2] = n2;
        repeat (2) @(negedge clk_i);
        for (int i = 0; i < 3; i++) begin
            len[i] = 4 << ln[i];
            pos[i] = 0;
            for (int j = 0; j < rem[i] * len[i]; j++) gen[i].push_back($urandom);
        end
        forever begin
            best = -1;
            for (int k = 0; k < 3; k++) begin
`ifdef MCDF_ARB_RR_EN
                ch = (rr_last + 1 + k) % 3;
`else
                ch = k;
`endif
                if (en[ch] && rem[ch] > 0 && (best < 0 || pr[ch] < pr[best])) best = ch;
            end
            if (best < 0) break;
            for (int j = 0; j < len[best]; j++) begin
                b.data = gen[best][pos[best] + j];
                b.id   = 2'(best);
                b.sop  = (j == 0);
                b.eop  = (j == len[best] - 1);
                exp_q.push_back(b);
            end
            pos[best] += len[best];
            rem[best]--;
            rr_last = best;
        end
        for (int i = 0; i < 3; i++) begin
            beats_sent[i] = 0; gap_cnt[i] = 0; blen[i] = len[i];
            ch_en[i] = en[i]; ch_prio[i] = pr[i]; ch_len[i] = ln[i];
            src_q[i] = gen[i];
        end
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 5000) begin
            @(negedge clk_i);
            cyc++;
        end
        check("drain_left", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(negedge clk_i);
        check("idle_busy", busy_o, 1'b0);
        for (int i = 0; i < 3; i++) src_q[i].delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, a_valid_o, 1'b0);
        check({tag, "_sop_eop"}, {a_sop_o, a_eop_o}, 2'b00);
        check({tag, "_busy"}, busy_o, 1'b0);
        check({tag, "_ready"}, ch_ready, 3'b000);
        check({tag, "_data"}, a_data_o, 32'd0);
        check({tag, "_id"}, a_id_o, 2'd0);
    endtask

    initial begin
        int cyc;
        repeat (3) @(negedge clk_i);
        check_reset_outputs("reset");
        rst_i = 1'b0;
        mon_en = 1'b1;

        // Equal priorities: order depends on tie-break policy.
        run_scenario(3'b111, 0, 0, 0, 0, 0, 0, 2, 1, 1);
        // Single 4-beat burst from ch0.
        run_scenario(3'b001, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        // Priority order 1, 0, 2.
        run_scenario(3'b111, 2, 1, 3, 0, 0, 0, 1, 1, 1);

        // Backpressure for 5 cycles inside an 8-beat burst.
        beats_out = 0;
        fork
            run_scenario(3'b001, 0, 0, 0, 1, 0, 0, 1, 0, 0);
            begin
                cyc = 0;
                while (beats_out < 3 && cyc < 200) begin
                    @(negedge clk_i);
                    cyc++;
                end
                check("bp_reached", (beats_out >= 3), 1'b1);
                bp_hold = 5;
            end
        join

        // ch2 16-beat burst: valid gap plus en/prio/len change after beat 3; ch0 has data but is disabled.
        hook_en = 1'b1;
        run_scenario(3'b100, 0, 0, 0, 0, 0, 2, 1, 0, 1);
        hook_en = 1'b0;

        gap_en = 1'b1;
        for (int s = 0; s < 15; s++) begin
            logic [2:0] en;
            en = 3'($urandom_range(7, 1));
            ready_pct = $urandom_range(100, 50);
            run_scenario(en, 2'($urandom), 2'($urandom), 2'($urandom),
                         2'($urandom_range(2)), 2'($urandom_range(3)), 2'($urandom_range(2)),
                         $urandom_range(2, 1), $urandom_range(2, 1), $urandom_range(2, 1));
        end
        gap_en = 1'b0;
        ready_pct = 100;

        // Reset at beat 5 of a 32-beat burst from ch1.
        mon_en = 1'b0;
        repeat (2) @(negedge clk_i);
        for (int i = 0; i < 3; i++) begin beats_sent[i] = 0; blen[i] = 32; end
        ch_prio[1] = 2'd0; ch_len[1] = 2'd3;
        for (int j = 0; j < 32; j++) src_q[1].push_back($urandom);
        ch_en[1] = 1'b1;
        cyc = 0;
        while (beats_sent[1] < 5 && cyc < 200) begin
            @(negedge clk_i);
            cyc++;
        end
        check("rst_beats_reached", beats_sent[1], 5);
        rst_i = 1'b1;
        for (int i = 0; i < 3; i++) ch_en[i] = 1'b0;
        @(negedge clk_i);
        check_reset_outputs("midrst");
        for (int i = 0; i < 3; i++) src_q[i].delete();
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        for (int i = 0; i < 3; i++) begin beats_sent[i] = 0; gap_cnt[i] = 0; end
        exp_q.delete();
        rr_last = 2;
        mon_en = 1'b1;
        // After reset the round-robin search starts at ch0.
        run_scenario(3'b111, 0, 0, 0, 0, 0, 0, 1, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

endmodule
